// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
//   Auto-play stage behind the song-select controller. Latches the selected
//   song on start, walks its note ROM entry by entry and drives a square-wave
//   buzzer at the pitch of the current note, with a silent gap between notes.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   song_num   in   [1:0] selected song from the song-select controller
//   start      in   level, begins playback when idle
//   stop       in   level, aborts playback (highest priority)
//   note       out  [4:0] current note code, 0 = silent
//   note_idx   out  [4:0] ROM index of the current entry
//   playing    out  high while loading, playing or in the inter-note gap
//   buzzer     out  square-wave tone output
//   song_done  out  one-cycle pulse when a song ends naturally
// ---------------------------------------------------------------------------
module song_sequencer #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int MAX_NOTES   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] song_num,
  input  logic       start,
  input  logic       stop,
  output logic [4:0] note,
  output logic [4:0] note_idx,
  output logic       playing,
  output logic       buzzer,
  output logic       song_done
);

  // Octave-4 half-periods in clock cycles (truncated)
  localparam int H4_C = CLK_FREQ / (2 * 262);
  localparam int H4_D = CLK_FREQ / (2 * 294);
  localparam int H4_E = CLK_FREQ / (2 * 330);
  localparam int H4_F = CLK_FREQ / (2 * 349);
  localparam int H4_G = CLK_FREQ / (2 * 392);
  localparam int H4_A = CLK_FREQ / (2 * 440);
  localparam int H4_B = CLK_FREQ / (2 * 494);

  // Longest half-period is C3 = 2*H4_C
  localparam int TONE_W  = $clog2(2 * H4_C + 1);
  localparam int DUR_MAX = (4 * BEAT_CYCLES > GAP_CYCLES) ? 4 * BEAT_CYCLES : GAP_CYCLES;
  localparam int DUR_W   = ($clog2(DUR_MAX + 1) > 27) ? $clog2(DUR_MAX + 1) : 27;

  localparam logic [4:0]        END_CODE = 5'd31;
  localparam logic [4:0]        LAST_IDX = 5'(MAX_NOTES - 1);
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
  localparam logic [TONE_W-1:0] TONE_ONE = TONE_W'(1);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

  // Note ROM: entry = {code[4:0], dur[1:0]}, beats = dur+1.
  // Unlisted entries read as the end marker.
  function automatic logic [6:0] rom_entry(input logic [1:0] s, input logic [4:0] i);
    logic [6:0] e;
    case ({s, i})
      // song 0: E4
      {2'd0, 5'd0}: e = {5'd10, 2'd0};
      // song 1: A3, C5 (2 beats), out-of-range code played as rest
      {2'd1, 5'd0}: e = {5'd6,  2'd0};
      {2'd1, 5'd1}: e = {5'd15, 2'd1};
      {2'd1, 5'd2}: e = {5'd25, 2'd0};
      // song 2: B4
      {2'd2, 5'd0}: e = {5'd14, 2'd0};
      // song 3: fixed test pattern C4, rest, G5 (2 beats)
      {2'd3, 5'd0}: e = {5'd8,  2'd0};
      {2'd3, 5'd1}: e = {5'd0,  2'd0};
      {2'd3, 5'd2}: e = {5'd19, 2'd1};
      default:      e = {END_CODE, 2'd0};
    endcase
    return e;
  endfunction

  // Half-period for a pitched code; 0 for anything that is not a pitch.
  function automatic logic [TONE_W-1:0] half_period(input logic [4:0] code);
    int         h;
    logic [2:0] pos;
    logic [1:0] oct;
    h   = 0;
    pos = 3'd0;
    oct = 2'd3;
    if (code >= 5'd1 && code <= 5'd7) begin
      pos = 3'(code - 5'd1);
      oct = 2'd0;
    end else if (code >= 5'd8 && code <= 5'd14) begin
      pos = 3'(code - 5'd8);
      oct = 2'd1;
    end else if (code >= 5'd15 && code <= 5'd21) begin
      pos = 3'(code - 5'd15);
      oct = 2'd2;
    end
    case (pos)
      3'd0:    h = H4_C;
      3'd1:    h = H4_D;
      3'd2:    h = H4_E;
      3'd3:    h = H4_F;
      3'd4:    h = H4_G;
      3'd5:    h = H4_A;
      3'd6:    h = H4_B;
      default: h = 0;
    endcase
    case (oct)
      2'd0:    h = 2 * h;
      2'd1:    h = h;
      2'd2:    h = h / 2;
      default: h = 0;
    endcase
    return TONE_W'(h);
  endfunction

  function automatic logic [DUR_W-1:0] beat_cycles(input logic [1:0] dur);
    logic [DUR_W-1:0] c;
    case (dur)
      2'd0:    c = DUR_W'(BEAT_CYCLES);
      2'd1:    c = DUR_W'(2 * BEAT_CYCLES);
      2'd2:    c = DUR_W'(3 * BEAT_CYCLES);
      default: c = DUR_W'(4 * BEAT_CYCLES);
    endcase
    return c;
  endfunction

  state_t            state;
  logic [1:0]        song;
  logic [DUR_W-1:0]  dur_cnt;
  logic [TONE_W-1:0] tone_cnt;
  logic [TONE_W-1:0] half;
  logic              tone_on;

  logic [6:0] rom_data;
  logic [4:0] rom_code;
  logic       busy;

  // ROM is addressed by the registered {song, idx}; its word is captured
  // into note/duration at the end of the single LOAD cycle.
  assign rom_data = rom_entry(song, note_idx);
  assign rom_code = rom_data[6:2];
  assign busy     = (state == LOAD) || (state == PLAY) || (state == GAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      song      <= 2'd0;
      note      <= 5'd0;
      note_idx  <= 5'd0;
      playing   <= 1'b0;
      buzzer    <= 1'b0;
      song_done <= 1'b0;
      dur_cnt   <= '0;
      tone_cnt  <= '0;
      half      <= '0;
      tone_on   <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (state != IDLE && stop) begin
        state    <= IDLE;
        note     <= 5'd0;
        note_idx <= 5'd0;
        playing  <= 1'b0;
        buzzer   <= 1'b0;
        tone_cnt <= '0;
      end else if (busy && song_num != song) begin
        // Selection changed mid-song: restart the new song from the top
        song     <= song_num;
        note_idx <= 5'd0;
        note     <= 5'd0;
        state    <= LOAD;
        playing  <= 1'b1;
        buzzer   <= 1'b0;
        tone_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              song     <= song_num;
              note_idx <= 5'd0;
              state    <= LOAD;
              playing  <= 1'b1;
            end
          end
          LOAD: begin
            if (rom_code == END_CODE) begin
              state     <= DONE;
              song_done <= 1'b1;
              playing   <= 1'b0;
            end else begin
              note     <= rom_code;
              dur_cnt  <= beat_cycles(rom_data[1:0]);
              half     <= half_period(rom_code);
              tone_on  <= (rom_code != 5'd0) && (rom_code <= 5'd21);
              tone_cnt <= '0;
              buzzer   <= 1'b0;
              state    <= PLAY;
            end
          end
          PLAY: begin
            if (dur_cnt == DUR_ONE) begin
              state    <= GAP;
              dur_cnt  <= DUR_W'(GAP_CYCLES);
              note     <= 5'd0;
              buzzer   <= 1'b0;
              tone_cnt <= '0;
            end else begin
              dur_cnt <= dur_cnt - DUR_ONE;
              if (tone_on) begin
                if (tone_cnt == half - TONE_ONE) begin
                  tone_cnt <= '0;
                  buzzer   <= ~buzzer;
                end else begin
                  tone_cnt <= tone_cnt + TONE_ONE;
                end
              end
            end
          end
          GAP: begin
            if (dur_cnt == DUR_ONE) begin
              // No wrap past the last ROM slot
              if (note_idx == LAST_IDX) begin
                state     <= DONE;
                song_done <= 1'b1;
                playing   <= 1'b0;
              end else begin
                note_idx <= note_idx + 5'd1;
                state    <= LOAD;
              end
            end else begin
              dur_cnt <= dur_cnt - DUR_ONE;
            end
          end
          DONE: begin
            state    <= IDLE;
            note     <= 5'd0;
            note_idx <= 5'd0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
